// File: rtl/lbist_pkg.sv
// Shared definitions for the LBIST test-pattern generator.
package lbist_pkg;

  localparam int unsigned LFSR_W = 24;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;
  localparam logic [LFSR_W-1:0] DEF_SEED  = 24'h5A5A5A;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CAPTURE,
    DONE
  } tpg_state_e;

  // Fibonacci step for x^24+x^23+x^22+x^17+1
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr24.sv
// 24-bit maximal-length LFSR with seed load; a zero seed is replaced so the
// register can never reach the all-zero lock-up state.
module lfsr24
  import lbist_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] lfsr_q
);

  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (step_en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/lbist_tpg.sv
// LBIST pattern generator: shift/capture sequencer and pattern counter around
// the 24-bit LFSR that feeds the phase shifter.
module lbist_tpg
  import lbist_pkg::*;
#(
  parameter int unsigned       SHIFT_LEN = 267,
  parameter int unsigned       PAT_W     = 16,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [PAT_W-1:0]  n_patterns,
  output logic [LFSR_W-1:0] lfsr_q,
  output logic              scan_en,
  output logic              capture,
  output logic              busy,
  output logic              done,
  output logic [PAT_W-1:0]  pat_cnt
);

  localparam int unsigned CNT_W = 16;

  tpg_state_e       state_q, state_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic [PAT_W-1:0] n_lat_q, n_lat_d;
  logic             scan_en_q, scan_en_d;
  logic             capture_q, capture_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lfsr_step;
  logic             lfsr_load;

  lfsr24 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_en(lfsr_step),
    .load_en(lfsr_load),
    .seed_in(seed_in),
    .lfsr_q (lfsr_q)
  );

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    n_lat_d     = n_lat_q;
    lfsr_step   = 1'b0;
    lfsr_load   = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          lfsr_load = seed_load;
          if (start) begin
            n_lat_d     = n_patterns;
            pat_cnt_d   = '0;
            shift_cnt_d = '0;
            state_d     = (n_patterns == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          lfsr_step   = 1'b1;
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
          if (shift_cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          pat_cnt_d   = pat_cnt_q + PAT_W'(1);
          shift_cnt_d = '0;
          state_d     = (pat_cnt_d == n_lat_q) ? DONE : SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered copies of the next-state decode
    scan_en_d = (state_d == SHIFT);
    capture_d = (state_d == CAPTURE);
    busy_d    = (state_d == SHIFT) || (state_d == CAPTURE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      n_lat_q     <= '0;
      scan_en_q   <= 1'b0;
      capture_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      n_lat_q     <= n_lat_d;
      scan_en_q   <= scan_en_d;
      capture_q   <= capture_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign scan_en = scan_en_q;
  assign capture = capture_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pat_cnt = pat_cnt_q;

endmodule

// File: tb/tb_lbist_tpg.sv
// Scoreboard bench for lbist_tpg with SHIFT_LEN=4: stimulus queues expected
// outputs, a negedge monitor pops and compares them.
module tb_lbist_tpg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        seed_load;
  logic [23:0] seed_in;
  logic [15:0] n_patterns;
  logic [23:0] lfsr_q;
  logic        scan_en;
  logic        capture;
  logic        busy;
  logic        done;
  logic [15:0] pat_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        se;
    logic        cap;
    logic        bsy;
    logic        dn;
    logic [15:0] pc;
    logic [23:0] lf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  lbist_tpg #(
    .SHIFT_LEN(4),
    .PAT_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .n_patterns(n_patterns),
    .lfsr_q    (lfsr_q),
    .scan_en   (scan_en),
    .capture   (capture),
    .busy      (busy),
    .done      (done),
    .pat_cnt   (pat_cnt)
  );

  function automatic logic [23:0] step24(input logic [23:0] q);
    return {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input logic se, input logic cap,
                          input logic bsy, input logic dn, input logic [15:0] pc,
                          input logic [23:0] lf);
    exp_t e;
    e.se = se; e.cap = cap; e.bsy = bsy; e.dn = dn; e.pc = pc; e.lf = lf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_direct(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  exp_t  mon_e;
  string mon_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if ({scan_en, capture, busy, done, pat_cnt, lfsr_q} !==
          {mon_e.se, mon_e.cap, mon_e.bsy, mon_e.dn, mon_e.pc, mon_e.lf}) begin
        errors++;
        $display("FAIL %s: got se=%b cap=%b busy=%b done=%b pat=%0d lfsr=%h want se=%b cap=%b busy=%b done=%b pat=%0d lfsr=%h",
                 mon_nm, scan_en, capture, busy, done, pat_cnt, lfsr_q,
                 mon_e.se, mon_e.cap, mon_e.bsy, mon_e.dn, mon_e.pc, mon_e.lf);
      end
    end
  end

  bit zero_seen = 1'b0;
  always @(negedge clk) if (rst_n === 1'b1 && lfsr_q === 24'h0) zero_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          p, pos;
  logic        se, cap, dn;
  logic [15:0] pc;
  logic [23:0] m;
  logic [23:0] one;
  int          nsh;

  task automatic start_run(input logic [23:0] s, input logic [15:0] n);
    seed_load = 1'b1; seed_in = s; start = 1'b1; n_patterns = n;
    tick();
    seed_load = 1'b0; start = 1'b0; seed_in = 24'h0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    seed_in = 24'h0; n_patterns = 16'd0; one = 24'h1;

    tick();
    expect_o("reset_hold", 0, 0, 0, 0, 16'd0, 24'h5A5A5A);
    tick();
    rst_n = 1'b1;
    tick();
    expect_o("idle_after_reset", 0, 0, 0, 0, 16'd0, 24'h5A5A5A);

    // Sequencing: two patterns of four shifts, n_patterns changed mid-run
    start_run(24'h000001, 16'd2);
    n_patterns = 16'd9;
    nsh = 0;
    for (int c = 1; c <= 11; c++) begin
      p = (c - 1) / 5; pos = (c - 1) % 5;
      se = (c <= 10) && (pos < 4);
      cap = (c <= 10) && (pos == 4);
      dn = (c == 11);
      pc = dn ? 16'd2 : 16'(p);
      expect_o($sformatf("seq_c%0d", c), se, cap, se | cap, dn, pc, one << nsh);
      if (c == 11) expect_o("seq_done", 0, 0, 0, 1, 16'd2, 24'h000100);
      if (se) nsh++;
      tick();
    end
    expect_o("seq_done_hold", 0, 0, 0, 1, 16'd2, 24'h000100);

    // Stepping from seed 1 across 20 shifts, started from DONE
    start_run(24'h000001, 16'd5);
    m = 24'h000001;
    for (int c = 1; c <= 26; c++) begin
      p = (c - 1) / 5; pos = (c - 1) % 5;
      se = (c <= 25) && (pos < 4);
      cap = (c <= 25) && (pos == 4);
      dn = (c == 26);
      pc = dn ? 16'd5 : 16'(p);
      expect_o($sformatf("step_c%0d", c), se, cap, se | cap, dn, pc, m);
      if (c == 2)  expect_o("step_1",  1, 0, 1, 0, 16'd0, 24'h000002);
      if (c == 20) expect_o("step_16", 0, 1, 1, 0, 16'd3, 24'h010000);
      if (c == 22) expect_o("step_17", 1, 0, 1, 0, 16'd4, 24'h020001);
      if (se) m = step24(m);
      tick();
    end

    seed_load = 1'b1; seed_in = 24'h0;
    tick();
    seed_load = 1'b0;
    expect_o("zero_seed", 0, 0, 0, 1, 16'd5, 24'h5A5A5A);

    start = 1'b1; n_patterns = 16'd0;
    tick();
    start = 1'b0;
    expect_o("zero_pat", 0, 0, 0, 1, 16'd0, 24'h5A5A5A);
    tick();
    expect_o("zero_pat_hold", 0, 0, 0, 1, 16'd0, 24'h5A5A5A);

    // Abort on the second shift of pattern two
    start_run(24'h000001, 16'd3);
    for (int i = 0; i < 6; i++) tick();
    expect_o("abort_pre", 1, 0, 1, 0, 16'd1, 24'h000020);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_o("abort_idle", 0, 0, 0, 0, 16'd1, 24'h000020);
    tick();
    expect_o("abort_hold", 0, 0, 0, 0, 16'd1, 24'h000020);

    // start/seed_load/n_patterns during SHIFT are ignored
    start_run(24'h000001, 16'd1);
    expect_o("ign_c1", 1, 0, 1, 0, 16'd0, 24'h000001);
    start = 1'b1; seed_load = 1'b1; seed_in = 24'hABCDEF; n_patterns = 16'd7;
    tick();
    expect_o("ign_shift", 1, 0, 1, 0, 16'd0, 24'h000002);
    tick();
    expect_o("ign_shift2", 1, 0, 1, 0, 16'd0, 24'h000004);
    start = 1'b0; seed_load = 1'b0;
    tick();
    tick();
    expect_o("ign_capture", 0, 1, 1, 0, 16'd0, 24'h000010);
    tick();
    expect_o("ign_done", 0, 0, 0, 1, 16'd1, 24'h000010);

    // Longer run against the polynomial model
    start_run(24'hC0FFEE, 16'd200);
    m = 24'hC0FFEE;
    for (int i = 0; i < 800; i++) m = step24(m);
    for (int i = 0; i < 1100 && done !== 1'b1; i++) tick();
    check_direct("long_timeout", 32'(done), 32'd1);
    expect_o("long_done", 0, 0, 0, 1, 16'd200, m);
    tick();
    check_direct("long_nonzero", 32'(zero_seen), 32'd0);

    // Asynchronous reset in the middle of a shift
    start_run(24'h000001, 16'd2);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    expect_o("reset_async", 0, 0, 0, 0, 16'd0, 24'h5A5A5A);
    tick();
    expect_o("reset_held", 0, 0, 0, 0, 16'd0, 24'h5A5A5A);
    rst_n = 1'b1;
    tick();
    expect_o("reset_idle", 0, 0, 0, 0, 16'd0, 24'h5A5A5A);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
